dili_ntt_core: RTL

Sequential, parametrised NTT/INTT engine for the Dilithium datapath.
- Replaces the single-layer, fully combinational 128-butterfly INTT stage with one time-multiplexed Montgomery butterfly.
- Runs all 8 layers of forward NTT or inverse NTT (with final `tomont` scaling) over an internal N-word coefficient register file.
- Coefficients are streamed in and out with valid/ready handshakes; twiddles are fetched from the external zeta table through an address/data port.
- Sits between the polynomial sampler/arith units and the pointwise multiplier.

---
 rtl/dili_ntt_core.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dili_ntt_core.sv
// dili_ntt_core: sequential Dilithium NTT/INTT engine.
// One shared Montgomery butterfly walks all layers over an N-word register file.
module dili_ntt_core #(
   parameter int WIDTH   = 32,
   parameter int Q       = 8380417,
   parameter int QINV    = 58728449,
   parameter int N       = 256,
   parameter int F_SCALE = 41978
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic                     mode_i,
   input  logic                     s_valid_i,
   output logic                     s_ready_o,
   input  logic [WIDTH-1:0]         s_data_i,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic [WIDTH-1:0]         m_data_o,
   output logic [$clog2(N)-1:0]     zeta_addr_o,
   input  logic [WIDTH-1:0]         zeta_i,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int LOGN = $clog2(N);
   localparam int LW   = $clog2(LOGN);
   localparam int W2   = 2 * WIDTH;
   localparam logic [WIDTH-1:0]      QINV_W = WIDTH'(QINV);
   localparam logic signed [W2-1:0] Q_W2   = W2'(Q);

   typedef enum logic [2:0] {IDLE, LOAD, CALC, SCALE, DRAIN} state_t;

   state_t              state_q, state_d;
   logic                mode_q;
   logic [LOGN-1:0]     cnt_q;
   logic [LW-1:0]       l_q;
   logic [LOGN-2:0]     i_q;
   logic [LOGN-1:0]     zaddr_q;
   logic                done_q;
   logic [WIDTH-1:0]    a [N];

   logic [LW-1:0]       sh;
   logic [LOGN-1:0]     lenv;
   logic [LOGN-2:0]     m;
   logic [LOGN-1:0]     j, jl, zaddr_c;
   logic                calc_last, cnt_last;
   logic signed [WIDTH-1:0] aj, ajl, mul_a, mul_b, mres;
   logic signed [W2-1:0]    prod, tq;
   logic [WIDTH-1:0]        tm;

   assign calc_last = (l_q == LW'(LOGN-1)) && (&i_q);
   assign cnt_last  = (cnt_q == LOGN'(N-1));

   // Butterfly addressing: sh = log2(len), j = 2*len*m + (i mod len).
   always_comb begin
      sh      = mode_q ? l_q : LW'(LOGN-1) - l_q;
      lenv    = LOGN'(1) << sh;
      m       = i_q >> sh;
      j       = ((LOGN'(m) << sh) << 1) | (LOGN'(i_q) & (lenv - LOGN'(1)));
      jl      = j + lenv;
      zaddr_c = mode_q ? LOGN'(N >> l_q) - LOGN'(1) - LOGN'(m)
                       : (LOGN'(1) << l_q) + LOGN'(m);
   end

   assign aj  = a[j];
   assign ajl = a[jl];

   always_comb begin
      mul_a = zeta_i;
      mul_b = ajl;
      if (state_q == SCALE) begin
         mul_a = WIDTH'(F_SCALE);
         mul_b = a[cnt_q];
      end else if (mode_q) begin
         mul_a = -zeta_i;
         mul_b = aj - ajl;
      end
   end

   // Montgomery reduction; the low half of prod - tq is zero by construction.
   assign prod = $signed({{WIDTH{mul_a[WIDTH-1]}}, mul_a})
               * $signed({{WIDTH{mul_b[WIDTH-1]}}, mul_b});
   assign tm   = prod[WIDTH-1:0] * QINV_W;
   assign tq   = $signed({{WIDTH{tm[WIDTH-1]}}, tm}) * Q_W2;
   assign mres = WIDTH'((prod - tq) >>> WIDTH);

   always_ff @(posedge clk_i) begin
      unique case (state_q)
         LOAD: if (s_valid_i) a[cnt_q] <= s_data_i;
         CALC: begin
            if (mode_q) begin
               a[j]  <= aj + ajl;
               a[jl] <= mres;
            end else begin
               a[j]  <= aj + mres;
               a[jl] <= aj - mres;
            end
         end
         SCALE:   a[cnt_q] <= mres;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_i) state_d = LOAD;
         LOAD:  if (s_valid_i && cnt_last) state_d = CALC;
         CALC:  if (calc_last) state_d = mode_q ? SCALE : DRAIN;
         SCALE: if (cnt_last) state_d = DRAIN;
         DRAIN: if (m_ready_i && cnt_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         l_q     <= '0;
         i_q     <= '0;
         zaddr_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == DRAIN) && m_ready_i && cnt_last;
         if (state_q == IDLE && start_i) mode_q <= mode_i;
         if ((state_q == LOAD && s_valid_i) || state_q == SCALE ||
             (state_q == DRAIN && m_ready_i))
            cnt_q <= cnt_q + LOGN'(1);
         if (state_q == CALC) begin
            zaddr_q <= zaddr_c;
            i_q     <= i_q + (LOGN-1)'(1);
            if (&i_q) l_q <= (l_q == LW'(LOGN-1)) ? '0 : l_q + LW'(1);
         end
      end
   end

   assign s_ready_o   = (state_q == LOAD);
   assign m_valid_o   = (state_q == DRAIN);
   assign m_data_o    = m_valid_o ? a[cnt_q] : '0;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign zeta_addr_o = (state_q == CALC) ? zaddr_c : zaddr_q;

endmodule
